// File: rtl/matrix_mem_burst.sv
// matrix_mem_burst
// Parametrised matrix row store with multi-word burst read/write. Addresses
// wrap modulo DEPTH, so a burst may cross the top of memory and continue at 0.
// Writes use a ready/valid handshake and may stall. Reads stream one word per
// cycle with no backpressure.
//
// Ports:
//   clk        system clock, all logic on posedge
//   Reset      synchronous active-high reset; clears memory and aborts bursts
//   nEnable    active-low burst request, sampled only in IDLE
//   ReadWrite  burst direction: 1 = read, 0 = write
//   start_addr first word address of the burst
//   burst_len  number of words, legal range 1..DEPTH
//   dataIN     write data
//   wr_valid   write beat valid
//   wr_ready   write beat accepted this cycle (high throughout WRITE)
//   dataOUT    registered read data, holds last read word
//   rd_valid   dataOUT carries a burst beat this cycle
//   busy       state != IDLE
//   done       one-cycle pulse at burst completion
//   err        one-cycle pulse on a rejected request
//
// state | meaning
// IDLE  | waiting for a request; bad lengths rejected here
// WRITE | accepting write beats, stalls while wr_valid is low
// READ  | streaming one word per cycle
// DONE  | completion cycle (done=1), returns to IDLE
module matrix_mem_burst #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              nEnable,
  input  logic              ReadWrite,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   burst_len,
  input  logic [DATA_W-1:0] dataIN,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] dataOUT,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   cnt;
  logic              lastBeat;

  assign lastBeat = (cnt == ONE);
  assign wr_ready = (state == WRITE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      addr     <= '0;
      cnt      <= '0;
      dataOUT  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!nEnable) begin
            if (burst_len == '0 || burst_len > MAX_LEN) begin
              err <= 1'b1;
            end else begin
              addr  <= start_addr;
              cnt   <= burst_len;
              state <= ReadWrite ? READ : WRITE;
            end
          end
        end
        WRITE: begin
          if (wr_valid) begin
            mem[addr] <= dataIN;
            // DEPTH is a power of two, so natural overflow gives the wrap
            addr      <= addr + 1'b1;
            cnt       <= cnt - 1'b1;
            if (lastBeat) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          dataOUT  <= mem[addr];
          rd_valid <= 1'b1;
          addr     <= addr + 1'b1;
          cnt      <= cnt - 1'b1;
          if (lastBeat) begin
            // done is raised together with the final beat so both are
            // visible during the DONE cycle
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mem_burst.sv
// Bench for matrix_mem_burst: table of burst operations with a read-data
// scoreboard, plus hand-written reset-abort and small-geometry sequences.
module tb_matrix_mem_burst;
  localparam int DW = 256;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset, nEnable, ReadWrite, wr_valid;
  logic [AW-1:0] start_addr;
  logic [AW:0]   burst_len;
  logic [DW-1:0] dataIN;
  logic          wr_ready, rd_valid, busy, done, err;
  logic [DW-1:0] dataOUT;

  matrix_mem_burst #(.DATA_W(DW), .DEPTH(8), .ADDR_W(AW)) dut (
    .clk(clk), .Reset(Reset), .nEnable(nEnable), .ReadWrite(ReadWrite),
    .start_addr(start_addr), .burst_len(burst_len), .dataIN(dataIN),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .dataOUT(dataOUT),
    .rd_valid(rd_valid), .busy(busy), .done(done), .err(err)
  );

  logic        sNEnable, sReadWrite, sWrValid;
  logic [3:0]  sStart;
  logic [4:0]  sLen;
  logic [15:0] sDataIN, sDataOUT;
  logic        sWrReady, sRdValid, sBusy, sDone, sErr;

  matrix_mem_burst #(.DATA_W(16), .DEPTH(16), .ADDR_W(4)) dutSmall (
    .clk(clk), .Reset(Reset), .nEnable(sNEnable), .ReadWrite(sReadWrite),
    .start_addr(sStart), .burst_len(sLen), .dataIN(sDataIN),
    .wr_valid(sWrValid), .wr_ready(sWrReady), .dataOUT(sDataOUT),
    .rd_valid(sRdValid), .busy(sBusy), .done(sDone), .err(sErr)
  );

  int passCnt = 0;
  int totalCnt = 0;

  function automatic void checkBit(string name, logic got, logic exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endfunction

  function automatic void checkWord(string name, logic [255:0] got, logic [255:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  // kind: 0 = write burst, 1 = read burst (d holds expected words), 2 = bad request
  typedef struct {
    int               kind;
    int               startAddr;
    int               len;
    int               stallAt;
    int               stallCyc;
    logic [0:7][31:0] d;
  } vec_t;

  function automatic vec_t mk(int kind, int startAddr, int len, int stallAt, int stallCyc,
                              logic [31:0] a0, logic [31:0] a1, logic [31:0] a2, logic [31:0] a3,
                              logic [31:0] a4, logic [31:0] a5, logic [31:0] a6, logic [31:0] a7);
    vec_t v;
    v.kind = kind; v.startAddr = startAddr; v.len = len;
    v.stallAt = stallAt; v.stallCyc = stallCyc;
    v.d[0] = a0; v.d[1] = a1; v.d[2] = a2; v.d[3] = a3;
    v.d[4] = a4; v.d[5] = a5; v.d[6] = a6; v.d[7] = a7;
    return v;
  endfunction

  logic [DW-1:0] expQ[$];
  logic [DW-1:0] monExp;

  always @(negedge clk) begin
    if (!Reset && rd_valid) begin
      if (expQ.size() == 0) begin
        checkBit("unexpected_rd_valid", rd_valid, 1'b0);
      end else begin
        monExp = expQ.pop_front();
        checkWord("rd_data", dataOUT, monExp);
      end
    end
  end

  task automatic request(input logic rw, input int start, input int len);
    ReadWrite  = rw;
    start_addr = AW'(start);
    burst_len  = (AW + 1)'(len);
    nEnable    = 1'b0;
    @(posedge clk); #1;
    nEnable    = 1'b1;
  endtask

  task automatic writeBurst(input vec_t v);
    request(1'b0, v.startAddr, v.len);
    for (int i = 0; i < v.len; i++) begin
      if (i == v.stallAt) begin
        for (int s = 0; s < v.stallCyc; s++) begin
          wr_valid = 1'b0;
          @(negedge clk);
          checkBit("stall_wr_ready", wr_ready, 1'b1);
          checkBit("stall_busy", busy, 1'b1);
          checkBit("stall_done", done, 1'b0);
          @(posedge clk); #1;
        end
      end
      wr_valid = 1'b1;
      dataIN   = {8{v.d[i]}};
      @(negedge clk);
      checkBit("wr_ready", wr_ready, 1'b1);
      checkBit("write_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    dataIN   = '0;
    @(negedge clk);
    checkBit("write_done", done, 1'b1);
    checkBit("write_done_busy", busy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkBit("write_done_clear", done, 1'b0);
    checkBit("write_idle_busy", busy, 1'b0);
  endtask

  task automatic readBurst(input vec_t v);
    int  nVal;
    bit  gotDone;
    nVal = 0;
    gotDone = 1'b0;
    for (int i = 0; i < v.len; i++) expQ.push_back({8{v.d[i]}});
    request(1'b1, v.startAddr, v.len);
    for (int c = 0; c < v.len + 4 && !gotDone; c++) begin
      @(negedge clk);
      if (c == 0) checkBit("read_busy", busy, 1'b1);
      if (rd_valid) nVal++;
      if (done) begin
        gotDone = 1'b1;
        checkBit("done_with_last_rd", rd_valid, 1'b1);
      end
    end
    checkBit("read_done_seen", gotDone, 1'b1);
    checkWord("rd_valid_beats", 256'(nVal), 256'(v.len));
    @(negedge clk);
    checkBit("rd_valid_after", rd_valid, 1'b0);
    checkBit("read_idle_busy", busy, 1'b0);
    checkBit("read_done_clear", done, 1'b0);
    checkWord("dataOUT_hold", dataOUT, {8{v.d[v.len-1]}});
  endtask

  task automatic badReq(input vec_t v);
    request(1'b0, v.startAddr, v.len);
    @(negedge clk);
    checkBit("err_pulse", err, 1'b1);
    checkBit("err_busy", busy, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkBit("err_clear", err, 1'b0);
    checkBit("err_busy_after", busy, 1'b0);
  endtask

  vec_t vecs[11];
  vec_t zeroRead;

  initial begin
    vecs[0]  = mk(0, 0, 2, -1, 0, 42, 56, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 2, -1, 0, 42, 56, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 6, 4, -1, 0, 5, 6, 7, 8, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 8, -1, 0, 7, 8, 0, 0, 0, 0, 5, 6);
    vecs[4]  = mk(0, 3, 1, -1, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 7, 5, -1, 0, 6, 7, 8, 0, 32'h77, 0, 0, 0);
    vecs[6]  = mk(2, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(2, 2, 9, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 8, -1, 0, 7, 8, 0, 32'h77, 0, 0, 5, 6);
    vecs[9]  = mk(0, 5, 3, 1, 2, 32'hA1, 32'hB2, 32'hC3, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 4, 4, -1, 0, 0, 32'hA1, 32'hB2, 32'hC3, 0, 0, 0, 0);
    zeroRead = mk(1, 0, 8, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    Reset = 1'b1; nEnable = 1'b1; ReadWrite = 1'b0; wr_valid = 1'b0;
    start_addr = '0; burst_len = '0; dataIN = '0;
    sNEnable = 1'b1; sReadWrite = 1'b0; sWrValid = 1'b0;
    sStart = '0; sLen = '0; sDataIN = '0;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    @(negedge clk);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_wr_ready", wr_ready, 1'b0);
    checkBit("rst_rd_valid", rd_valid, 1'b0);
    checkBit("rst_done", done, 1'b0);
    checkBit("rst_err", err, 1'b0);
    checkWord("rst_dataOUT", dataOUT, '0);

    for (int i = 0; i < 11; i++) begin
      case (vecs[i].kind)
        0:       writeBurst(vecs[i]);
        1:       readBurst(vecs[i]);
        default: badReq(vecs[i]);
      endcase
    end

    // Reset lands on the 3rd beat of a 5-word write
    request(1'b0, 0, 5);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      dataIN   = {8{32'h11 * (i + 1)}};
      @(posedge clk); #1;
    end
    dataIN = {8{32'h33}};
    Reset  = 1'b1;
    @(posedge clk); #1;
    Reset    = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    checkBit("abort_busy", busy, 1'b0);
    checkBit("abort_rd_valid", rd_valid, 1'b0);
    checkBit("abort_done", done, 1'b0);
    checkBit("abort_wr_ready", wr_ready, 1'b0);
    readBurst(zeroRead);

    // 16x16 geometry: single word at the top address
    sReadWrite = 1'b0; sStart = 4'd15; sLen = 5'd1; sNEnable = 1'b0;
    @(posedge clk); #1;
    sNEnable = 1'b1; sWrValid = 1'b1; sDataIN = 16'hABCD;
    @(negedge clk);
    checkBit("small_wr_ready", sWrReady, 1'b1);
    @(posedge clk); #1;
    sWrValid = 1'b0;
    @(negedge clk);
    checkBit("small_write_done", sDone, 1'b1);
    @(posedge clk); #1;
    sReadWrite = 1'b1; sNEnable = 1'b0;
    @(posedge clk); #1;
    sNEnable = 1'b1;
    @(negedge clk);
    checkBit("small_rd_valid_pre", sRdValid, 1'b0);
    @(negedge clk);
    checkBit("small_rd_valid", sRdValid, 1'b1);
    checkBit("small_read_done", sDone, 1'b1);
    checkWord("small_dataOUT", 256'(sDataOUT), 256'(16'hABCD));
    @(negedge clk);
    checkBit("small_rd_valid_post", sRdValid, 1'b0);
    checkBit("small_busy_post", sBusy, 1'b0);
    checkBit("small_err", sErr, 1'b0);

    repeat (2) @(negedge clk);
    checkWord("scoreboard_empty", 256'(expQ.size()), 256'(0));
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/matrix_mem_burst.md
Name: matrix_mem_burst

Overview:
- Parametrised successor to the 8×256-bit matrix RAM.
- Adds configurable width and depth, plus multi-word burst read/write with wrap-around addressing, a write handshake, and done/error status.
- Separate input and output data buses replace the shared tri-state bus.
- Sits between the matrix engine datapath and the result register; stores matrix rows, one row per word.

Parameters:
- DATA_W, 256, word width in bits (one matrix row).
- DEPTH, 8, number of words; must be a power of two.
- ADDR_W, 3, address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic is on the posedge.
- Reset  in  1  synchronous, active-high reset.
- nEnable  in  1  active-low burst request; sampled only in IDLE.
- ReadWrite  in  1  burst direction: 1 = read, 0 = write; sampled with nEnable.
- start_addr  in  ADDR_W  first word address of the burst.
- burst_len  in  ADDR_W+1  number of words, legal range 1..DEPTH.
- dataIN  in  DATA_W  write data.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  block accepts a write beat this cycle.
- dataOUT  out  DATA_W  read data, registered.
- rd_valid  out  1  dataOUT holds a valid burst beat.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high. While Reset=1 at a posedge:
  - state goes to IDLE;
  - all memory words are cleared to 0;
  - wr_ready, rd_valid, busy, done and err are 0, and dataOUT is 0.
- Reset also aborts any burst in progress; no partial write completes after Reset.
- States: IDLE, WRITE, READ, DONE.
- IDLE, nEnable=0 at a posedge:
  - If burst_len is 0 or greater than DEPTH: err=1 for the next cycle only, and state stays IDLE.
  - Otherwise latch start_addr into addr and burst_len into cnt, then go to WRITE (ReadWrite=0) or READ (ReadWrite=1).
- nEnable, ReadWrite, start_addr and burst_len are ignored outside IDLE.
- WRITE:
  - wr_ready=1 combinationally.
  - Each posedge with wr_valid=1 writes mem[addr]<=dataIN, sets addr<=addr+1 mod DEPTH, and cnt<=cnt-1.
  - A posedge with wr_valid=0 is a stall: no state change.
  - The beat with cnt==1 moves to DONE.
- READ:
  - No backpressure.
  - Each posedge sets dataOUT<=mem[addr], rd_valid<=1, addr<=addr+1 mod DEPTH, and cnt<=cnt-1.
  - The beat with cnt==1 moves to DONE.
  - First data is visible one cycle after the accepting edge. rd_valid is high for exactly burst_len consecutive cycles.
- DONE:
  - done=1 for one cycle, then return to IDLE.
  - For reads, this cycle coincides with the final rd_valid beat.
  - A new request is accepted earliest at the edge that leaves DONE+1, i.e. in IDLE.
- dataOUT holds the last read word until the next read beat or Reset. rd_valid=0 outside read beats.
- Address wrap: a burst crossing DEPTH-1 continues at 0. burst_len=DEPTH from any start touches every word exactly once.
- Reads return the contents at the read edge. No same-cycle read/write conflict exists, since the state is exclusive.
- Reads after Reset return 0.
- A burst of length 1 reproduces single-word legacy access.

Test Plan:
1. Reset, then write burst at start_addr=0, burst_len=2, with dataIN 42 then 56 and wr_valid held high. Then read burst from addr 0, len 2. Required: dataOUT=42 then 56 on consecutive rd_valid cycles; done coincides with the 56 beat.
2. Write at start_addr=6, len=4, data 5,6,7,8. Then read at start_addr=0, len=8. Required: sequence 7,8,0,0,0,0,5,6, confirming wrap-around.
3. Write burst len=3 with wr_valid low for 2 cycles between beats 1 and 2. Required: wr_ready stays 1, no extra writes, done 1 cycle after beat 3, busy high for the whole burst.
4. Request with burst_len=0, then with burst_len=9 (DEPTH=8). Required: err pulses one cycle each, busy stays 0, memory unchanged.
5. Reset asserted during the 3rd beat of a len-5 write. Required: next cycle busy=0 and rd_valid=0; a read of all 8 words returns 0.
6. Instantiate DATA_W=16, DEPTH=16, ADDR_W=4. Write 0xABCD at address 15, len 1, then read len 1. Required: dataOUT=16'hABCD, rd_valid high for one cycle.
